// File: rtl/dmux_lane_scheduler_pkg.sv
// Shared types and defaults for the demux lane scheduler.
// The state encodings are fixed so that waveforms and any external monitors agree.
package dmux_lane_scheduler_pkg;

    localparam int DEF_NUM_LANES = 8;
    localparam int DEF_SEL_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dmux_lane_scheduler_lane_next_finder.sv
// Combinational lane search over a lane mask: lowest set lane, next set lane
// strictly above the current select, and a flag when no set lane lies above it.
module dmux_lane_scheduler_lane_next_finder
    import dmux_lane_scheduler_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic [NUM_LANES-1:0] i_mask,
    input  logic [SEL_W-1:0]     i_sel,
    output logic [SEL_W-1:0]     o_next,
    output logic [SEL_W-1:0]     o_lowest,
    output logic                 o_none_above
);

    // Scan downward so the last hit is the lowest qualifying lane.
    always_comb begin
        o_next       = '0;
        o_lowest     = '0;
        o_none_above = 1'b1;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (i_mask[i] && (SEL_W'(i) > i_sel)) begin
                o_next       = SEL_W'(i);
                o_none_above = 1'b0;
            end
            if (i_mask[i]) begin
                o_lowest = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/dmux_lane_scheduler.sv
// Frame sequencer for an N-way 1-bit demux: steps the select through the
// enabled lanes of a latched mask and captures each accepted serial bit.
module dmux_lane_scheduler
    import dmux_lane_scheduler_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int SEL_W     = DEF_SEL_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [NUM_LANES-1:0] i_lane_en,
    input  logic                 i_in,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    output logic [SEL_W-1:0]     o_sel,
    output logic [NUM_LANES-1:0] o_out,
    output logic                 o_frame_valid,
    output logic                 o_busy
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_LANES-1:0]   r_mask;
    logic [SEL_W-1:0]       r_sel;
    logic [NUM_LANES-1:0]   r_out;

    logic [NUM_LANES-1:0]   w_mask;
    logic [SEL_W-1:0]       w_next;
    logic [SEL_W-1:0]       w_lowest;
    logic                   w_none_above;
    logic                   w_accept;
    logic                   w_fire;

    // One finder serves both paths: in IDLE it looks at the incoming mask to
    // pick the first lane, otherwise at the latched mask to advance.
    assign w_mask   = (r_state == ST_IDLE) ? i_lane_en : r_mask;
    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_fire   = (r_state == ST_RUN) && i_in_valid;

    dmux_lane_scheduler_lane_next_finder #(
        .NUM_LANES (NUM_LANES),
        .SEL_W     (SEL_W)
    ) u_finder (
        .i_mask       (w_mask),
        .i_sel        (r_sel),
        .o_next       (w_next),
        .o_lowest     (w_lowest),
        .o_none_above (w_none_above)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_lane_en == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_fire && w_none_above) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Select and lane registers move only on an accepted Start or a transfer;
    // on the final transfer the select parks on the highest enabled lane.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mask <= '0;
            r_sel  <= '0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_mask <= i_lane_en;
            r_sel  <= w_lowest;
            r_out  <= '0;
        end else if (w_fire) begin
            r_out[r_sel] <= i_in;
            if (!w_none_above) begin
                r_sel <= w_next;
            end
        end
    end

    assign o_in_ready    = (r_state == ST_RUN);
    assign o_frame_valid = (r_state == ST_DONE);
    assign o_busy        = (r_state != ST_IDLE);
    assign o_sel         = r_sel;
    assign o_out         = r_out;

endmodule

// File: tb/tb_dmux_lane_scheduler.sv
// Directed table-driven bench for the demux lane scheduler.
module tb_dmux_lane_scheduler;

    localparam int NL = 8;
    localparam int SW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [NL-1:0] lane_en;
    logic          din;
    logic          dv;
    logic          in_ready;
    logic [SW-1:0] sel;
    logic [NL-1:0] dout;
    logic          fv;
    logic          busy;

    int n_total = 0;
    int n_pass  = 0;

    dmux_lane_scheduler #(.NUM_LANES(NL), .SEL_W(SW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_lane_en     (lane_en),
        .i_in          (din),
        .i_in_valid    (dv),
        .o_in_ready    (in_ready),
        .o_sel         (sel),
        .o_out         (dout),
        .o_frame_valid (fv),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs applied before a rising edge, and the outputs expected after it.
    typedef struct {
        logic          rst;
        logic          start;
        logic [NL-1:0] en;
        logic          din;
        logic          dv;
        logic          rdy;
        logic [SW-1:0] sel;
        logic [NL-1:0] out;
        logic          fv;
        logic          busy;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(logic r, logic s, logic [NL-1:0] e, logic d, logic dvl,
                               logic rdy, logic [SW-1:0] sl, logic [NL-1:0] o,
                               logic f, logic b);
        vec_t x;
        x.rst = r; x.start = s; x.en = e; x.din = d; x.dv = dvl;
        x.rdy = rdy; x.sel = sl; x.out = o; x.fv = f; x.busy = b;
        return x;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        int cyc;
        int rdy_cnt;

        rst = 1'b1; start = 1'b0; lane_en = '0; din = 1'b0; dv = 1'b0;

        //          rst s  en     d  dv   rdy sel out    fv busy
        // reset
        vq.push_back(v(1, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0));
        vq.push_back(v(0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 0));
        // full frame, bits 1,0,1,1,0,0,1,0
        vq.push_back(v(0, 1, 8'hFF, 0, 0,  1, 0, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 1, 8'h01, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 2, 8'h01, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 3, 8'h05, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 4, 8'h0D, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 5, 8'h0D, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 6, 8'h0D, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 7, 8'h4D, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  0, 7, 8'h4D, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 7, 8'h4D, 0, 0));
        // sparse mask 1010_0100, bits 1,1,1
        vq.push_back(v(0, 1, 8'hA4, 0, 0,  1, 2, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 5, 8'h04, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 7, 8'h24, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 7, 8'hA4, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 0,  0, 7, 8'hA4, 0, 0));
        // 3-cycle stall after the 2nd bit, bits 0,1,1,0,1,0,0,1
        vq.push_back(v(0, 1, 8'hFF, 0, 0,  1, 0, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 1, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 2, 8'h02, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 0,  1, 2, 8'h02, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 0,  1, 2, 8'h02, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 0,  1, 2, 8'h02, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 3, 8'h06, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 4, 8'h06, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 5, 8'h16, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 6, 8'h16, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 7, 8'h16, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 7, 8'h96, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 0,  0, 7, 8'h96, 0, 0));
        // empty mask: straight to DONE, In ignored
        vq.push_back(v(0, 1, 8'h00, 1, 1,  0, 0, 8'h00, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 0, 8'h00, 0, 0));
        // reset after 4 transfers, then mask 0F, bits 1,0,1,0
        vq.push_back(v(0, 1, 8'hFF, 0, 0,  1, 0, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 1, 8'h01, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 2, 8'h03, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 3, 8'h07, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 4, 8'h0F, 0, 1));
        vq.push_back(v(1, 0, 8'h00, 1, 1,  0, 0, 8'h00, 0, 0));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 0, 8'h00, 0, 0));
        vq.push_back(v(0, 1, 8'h0F, 0, 0,  1, 0, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 1, 8'h01, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 2, 8'h01, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 3, 8'h05, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  0, 3, 8'h05, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 0,  0, 3, 8'h05, 0, 0));
        // Start/Lane_En toggled in RUN and DONE, then a real Start in IDLE
        vq.push_back(v(0, 1, 8'h03, 0, 0,  1, 0, 8'h00, 0, 1));
        vq.push_back(v(0, 1, 8'hFF, 1, 1,  1, 1, 8'h01, 0, 1));
        vq.push_back(v(0, 1, 8'hF0, 1, 1,  0, 1, 8'h03, 1, 1));
        vq.push_back(v(0, 1, 8'hF0, 0, 0,  0, 1, 8'h03, 0, 0));
        vq.push_back(v(0, 1, 8'hF0, 0, 0,  1, 4, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 5, 8'h10, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 1,  1, 6, 8'h10, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  1, 7, 8'h50, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 7, 8'hD0, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 0,  0, 7, 8'hD0, 0, 0));
        // single lane 7
        vq.push_back(v(0, 1, 8'h80, 0, 0,  1, 7, 8'h00, 0, 1));
        vq.push_back(v(0, 0, 8'h00, 1, 1,  0, 7, 8'h80, 1, 1));
        vq.push_back(v(0, 0, 8'h00, 0, 0,  0, 7, 8'h80, 0, 0));

        for (int r = 0; r < vq.size(); r++) begin
            rst = vq[r].rst; start = vq[r].start; lane_en = vq[r].en;
            din = vq[r].din; dv = vq[r].dv;
            @(posedge clk); #1;
            chk($sformatf("row%0d.in_ready", r), 32'(in_ready), 32'(vq[r].rdy));
            chk($sformatf("row%0d.sel", r),      32'(sel),      32'(vq[r].sel));
            chk($sformatf("row%0d.out", r),      32'(dout),     32'(vq[r].out));
            chk($sformatf("row%0d.frame_valid", r), 32'(fv),    32'(vq[r].fv));
            chk($sformatf("row%0d.busy", r),     32'(busy),     32'(vq[r].busy));
        end

        // Latency: all-ones frame with In_Valid held high from the Start edge.
        rst = 1'b0; start = 1'b1; lane_en = 8'hFF; din = 1'b1; dv = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; lane_en = '0; dv = 1'b1;
        cyc = 0; rdy_cnt = 0;
        while (cyc < 20) begin
            if (in_ready) rdy_cnt++;
            @(posedge clk); #1;
            cyc++;
            if (fv) break;
        end
        dv = 1'b0;
        chk("lat.cycles_to_fv", 32'(cyc), 32'd8);
        chk("lat.fv_seen", 32'(fv), 32'd1);
        chk("lat.ready_cycles", 32'(rdy_cnt), 32'd8);
        chk("lat.out", 32'(dout), 32'hFF);
        @(posedge clk); #1;
        chk("lat.fv_one_cycle", 32'(fv), 32'd0);
        chk("lat.busy_drop", 32'(busy), 32'd0);
        chk("lat.out_hold", 32'(dout), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
